mic_frame_writer: RTL
=====================

Name: mic_frame_writer

Overview:
- Sits directly downstream of the per-mic combined_filter instances.
- Collects one 16-bit decimated sample per microphone into a frame and packs each frame into 32-bit words.
- Writes the words into the on-chip RAM slave port s2 as a two-bank ping-pong buffer.
- Publishes per-bank full flags that the Nios II clears with an acknowledge once it has shipped a bank over Ethernet.

Parameters:
- MIC_N, 2, number of microphone channels (1..16).
- ADDR_W, 10, RAM word-address width.
- BANK_WORDS, 512, words per bank. Must be a multiple of WPF; 2*BANK_WORDS <= 2**ADDR_W.
- WPF (localparam), ceil(MIC_N/2), words per frame.

Ports:
- clk  in  1  system clock; the filter outputs and RAM port s2 are in this domain.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  frames are accepted only while high.
- sample_valid  in  MIC_N  per-channel sample strobe (av_st_out.valid).
- sample_data  in  16*MIC_N  channel c occupies bits [16c+15:16c]; signed.
- ram_address  out  ADDR_W  s2 word address.
- ram_write  out  1  s2 write strobe.
- ram_writedata  out  32  s2 write data.
- ram_byteenable  out  4  constant 4'b1111.
- ram_chipselect  out  1  equal to ram_write.
- ram_clken  out  1  constant 1.
- bank_full  out  2  bit b set means bank b is complete and awaiting ack.
- buf_ack  in  1  one-cycle pulse: clear bank_full[ack_bank].
- ack_bank  in  1  bank being acknowledged.
- drop_count  out  16  frames dropped because the target bank was full; saturating.
- sample_overrun  out  1  sticky: a channel received a new sample before the previous one was framed.

Behaviour:
- Reset values: all outputs 0 except ram_byteenable=4'hF and ram_clken=1. Internal state: cur_bank=0, word_ptr=0, have[]=0, FSM=COLLECT.
- Capture:
  - On sample_valid[c] with enable=1: hold[c]<=data and have[c]<=1.
  - If have[c] was already 1 and no transfer occurs that cycle: replace the held value and set sample_overrun.
- Frame transfer: when all have[] are 1 in state COLLECT:
  - In the same edge, copy hold[] to the frame shadow register and clear have[].
  - A sample_valid[c] in that same cycle sets have[c] again with the new data; this is not an overrun.
- Drop rule: at transfer, if bank_full[cur_bank]=1, discard the frame, increment drop_count (saturating at 16'hFFFF), and stay in COLLECT.
- FSM:
  - COLLECT -> WRITE on a non-dropped transfer.
  - WRITE emits one word per cycle, word w = 0..WPF-1.
  - WRITE -> COLLECT after word WPF-1.
  - Transfers are not taken while in WRITE; have[] keeps accumulating.
- Packing: word w carries low half = channel 2w and high half = channel 2w+1. When MIC_N is odd, the high half of the last word is 16'h0000.
- Addressing: ram_address = cur_bank*BANK_WORDS + word_ptr.
  - word_ptr increments on every write.
  - On the write with word_ptr = BANK_WORDS-1: set bank_full[cur_bank] at that edge, wrap word_ptr to 0, toggle cur_bank.
- Latency: if the completing sample is registered at edge t, ram_write is high in cycles t+1 .. t+WPF.
- Ack handling:
  - buf_ack clears bank_full[ack_bank].
  - An ack of a bank that is not full is ignored.
  - An ack and a fill of the other bank in the same cycle are both applied.
  - Fill and ack of the same bank cannot coincide, because writes only target non-full banks.
- enable=0:
  - have[] are cleared and new samples are ignored.
  - A frame already in WRITE completes.
  - word_ptr, cur_bank and the flags are retained.
- rst mid-write: the write stops immediately and all state returns to reset values. Partial bank contents are abandoned and not flagged.

Decomposition:
- Package mic_array_pkg holds:
  - SAMPLE_W=16, RAM_DATA_W=32, BANKS=2;
  - a function words_per_frame(MIC_N);
  - the FSM state enum {COLLECT, WRITE}.
- One natural sub-module: mic_sample_capture. It owns the per-channel hold/have registers, the overrun detection, and the frame_ready/frame_take handshake to the writer FSM.

Test Plan:
- MIC_N=2, BANK_WORDS=4; both valids together with ch0=16'h1234, ch1=16'hABCD -> one write next cycle, addr 0, data 32'hABCD1234.
- Stagger: ch0 valid at cycle 0, ch1 valid at cycle 5 -> no write before cycle 6; the write occurs in cycle 6.
- Eight frames with no ack -> bank_full becomes 2'b01 after frame 4 (addresses 0-3) and 2'b11 after frame 8 (addresses 4-7). Frame 9 is dropped (drop_count=1, no write). buf_ack with ack_bank=0 -> bank_full=2'b10, and frame 10 is written to addr 0.
- MIC_N=3: frame (1,2,3) -> two writes, 32'h00020001 then 32'h00000003, at consecutive cycles.
- Two ch0 valids before any ch1 valid -> sample_overrun=1; the frame carries the second ch0 value.
- rst asserted during the second word of a MIC_N=3 write -> ram_write=0 the next cycle; all outputs at reset values; the next frame is written at addr 0.

Source files
------------

// File: rtl/mic_frame_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mic_array_pkg
//  Purpose  : Shared constants, FSM state type and frame-geometry helper for
//             the microphone frame writer and its capture stage.
//  Contents : SAMPLE_W, RAM_DATA_W, BANKS, fsm_state_t, words_per_frame()
//  Revision : 1.0 - initial release
// ============================================================================
package mic_array_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int RAM_DATA_W = 32;
  localparam int BANKS      = 2;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    WRITE   = 1'b1
  } fsm_state_t;

  // Two 16-bit samples fit in one RAM word; an odd channel count leaves the
  // upper half of the last word empty.
  function automatic int words_per_frame(input int mic_n);
    return (mic_n + 1) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mic_frame_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mic_frame_writer_if
//  Purpose  : Avalon-MM style write port toward on-chip RAM slave s2.
//  Signals  : ram_address    - word address
//             ram_write      - write strobe
//             ram_writedata  - 32-bit write data
//             ram_byteenable - byte enables (always all ones)
//             ram_chipselect - follows ram_write
//             ram_clken      - clock enable (always one)
//  Modports : master (frame writer drives), slave (RAM side observes)
//  Revision : 1.0 - initial release
// ============================================================================
interface mic_frame_writer_if #(
  parameter int ADDR_W = 10
);

  logic [ADDR_W-1:0]                      ram_address;
  logic                                   ram_write;
  logic [mic_array_pkg::RAM_DATA_W-1:0]   ram_writedata;
  logic [3:0]                             ram_byteenable;
  logic                                   ram_chipselect;
  logic                                   ram_clken;

  modport master (
    output ram_address, ram_write, ram_writedata,
           ram_byteenable, ram_chipselect, ram_clken
  );

  modport slave (
    input  ram_address, ram_write, ram_writedata,
           ram_byteenable, ram_chipselect, ram_clken
  );

endinterface
`default_nettype wire

// File: rtl/mic_frame_writer_capture.sv
`default_nettype none
// ============================================================================
//  Module   : mic_sample_capture
//  Purpose  : Holds the latest sample of every channel until a full frame is
//             available, flags overruns and hands the frame to the writer.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             enable            - samples accepted only while high
//             sample_valid/data - per-channel sample strobes and data
//             frame_take        - writer consumes the frame this cycle
//             frame_ready       - every channel has (or is receiving) a sample
//             frame_data        - frame contents to latch on frame_take
//             sample_overrun    - sticky overrun flag
//  Revision : 1.0 - initial release
// ============================================================================
module mic_sample_capture
  import mic_array_pkg::*;
#(
  parameter int MIC_N = 2
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  input  wire logic                      enable,
  input  wire logic [MIC_N-1:0]          sample_valid,
  input  wire logic [SAMPLE_W*MIC_N-1:0] sample_data,
  input  wire logic                      frame_take,
  output logic                           frame_ready,
  output logic [SAMPLE_W*MIC_N-1:0]      frame_data,
  output logic                           sample_overrun
);

  logic [MIC_N-1:0]          have;
  logic [SAMPLE_W*MIC_N-1:0] hold;

  // A channel whose sample arrives in the same cycle as the last missing one
  // counts as present; its data bypasses the hold register straight into the
  // frame, which gives the one-cycle sample-to-write latency.
  always_comb begin
    frame_ready = enable && (&(have | sample_valid));
    frame_data  = '0;
    for (int c = 0; c < MIC_N; c++) begin
      frame_data[c*SAMPLE_W +: SAMPLE_W] = have[c] ? hold[c*SAMPLE_W +: SAMPLE_W]
                                                   : sample_data[c*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      have           <= '0;
      hold           <= '0;
      sample_overrun <= 1'b0;
    end else if (!enable) begin
      have <= '0;
    end else begin
      for (int c = 0; c < MIC_N; c++) begin
        if (frame_take) begin
          // Held value went into the frame; a strobe arriving now starts the
          // next frame. A strobe on an empty channel was consumed directly.
          if (have[c] && sample_valid[c]) begin
            hold[c*SAMPLE_W +: SAMPLE_W] <= sample_data[c*SAMPLE_W +: SAMPLE_W];
            have[c]                      <= 1'b1;
          end else begin
            have[c] <= 1'b0;
          end
        end else if (sample_valid[c]) begin
          hold[c*SAMPLE_W +: SAMPLE_W] <= sample_data[c*SAMPLE_W +: SAMPLE_W];
          have[c]                      <= 1'b1;
          if (have[c]) begin
            sample_overrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mic_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module   : mic_frame_writer
//  Purpose  : Packs one sample per microphone into a frame of 32-bit words and
//             writes frames into a two-bank ping-pong buffer in on-chip RAM.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             enable            - frame acceptance enable
//             sample_valid/data - per-channel decimated samples
//             ram               - RAM s2 write port (master modport)
//             bank_full         - per-bank complete flags
//             buf_ack/ack_bank  - software acknowledge of a shipped bank
//             drop_count        - saturating count of frames lost to full banks
//             sample_overrun    - sticky capture overrun flag
//  Revision : 1.0 - initial release
// ============================================================================
module mic_frame_writer
  import mic_array_pkg::*;
#(
  parameter int MIC_N      = 2,
  parameter int ADDR_W     = 10,
  parameter int BANK_WORDS = 512
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  input  wire logic                      enable,
  input  wire logic [MIC_N-1:0]          sample_valid,
  input  wire logic [SAMPLE_W*MIC_N-1:0] sample_data,
  mic_frame_writer_if.master             ram,
  output logic [BANKS-1:0]               bank_full,
  input  wire logic                      buf_ack,
  input  wire logic                      ack_bank,
  output logic [15:0]                    drop_count,
  output logic                           sample_overrun
);

  localparam int WPF      = words_per_frame(MIC_N);
  localparam int WIDX_W   = (WPF > 1) ? $clog2(WPF) : 1;
  localparam int PTR_W    = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
  localparam int SHADOW_W = WPF * RAM_DATA_W;

  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(BANK_WORDS);
  localparam logic [WIDX_W-1:0] LAST_WORD  = WIDX_W'(WPF - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(BANK_WORDS - 1);

  fsm_state_t                state;
  fsm_state_t                state_next;

  logic                      frame_ready;
  logic                      frame_take;
  logic                      drop;
  logic [SAMPLE_W*MIC_N-1:0] frame_data;
  logic [SHADOW_W-1:0]       shadow;
  logic [SHADOW_W-1:0]       shadow_next;
  logic [WIDX_W-1:0]         word_idx;
  logic [PTR_W-1:0]          word_ptr;
  logic                      cur_bank;
  logic [BANKS-1:0]          bank_full_next;
  logic                      writing;
  logic                      last_word;
  logic                      bank_wrap;
  logic [RAM_DATA_W-1:0]     word_mux [2**WIDX_W];

  mic_sample_capture #(
    .MIC_N (MIC_N)
  ) u_capture (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .sample_valid   (sample_valid),
    .sample_data    (sample_data),
    .frame_take     (frame_take),
    .frame_ready    (frame_ready),
    .frame_data     (frame_data),
    .sample_overrun (sample_overrun)
  );

  // Frames are only taken between writes; a frame aimed at a full bank is
  // still taken (so capture restarts) but is discarded.
  assign frame_take = frame_ready && (state == COLLECT);
  assign drop       = frame_take && bank_full[cur_bank];
  assign writing    = (state == WRITE);
  assign last_word  = (word_idx == LAST_WORD);
  assign bank_wrap  = (word_ptr == LAST_PTR);

  // Word view of the frame shadow; slots beyond the frame read as zero.
  for (genvar w = 0; w < 2**WIDX_W; w++) begin : g_words
    if (w < WPF) begin : g_live
      assign word_mux[w] = shadow[w*RAM_DATA_W +: RAM_DATA_W];
    end else begin : g_pad
      assign word_mux[w] = '0;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (frame_take && !drop) state_next = WRITE;
      WRITE:   if (last_word)           state_next = COLLECT;
      default:                          state_next = COLLECT;
    endcase
  end

  always_comb begin
    ram.ram_write      = writing;
    ram.ram_chipselect = writing;
    ram.ram_byteenable = 4'hF;
    ram.ram_clken      = 1'b1;
    ram.ram_address    = (cur_bank ? BANK1_BASE : '0) + ADDR_W'(word_ptr);
    ram.ram_writedata  = word_mux[word_idx];
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    bank_full_next = bank_full;
    if (buf_ack) begin
      bank_full_next[ack_bank] = 1'b0;
    end
    // Writes never target a full bank, so this cannot collide with an ack of
    // the same bank.
    if (writing && bank_wrap) begin
      bank_full_next[cur_bank] = 1'b1;
    end

    // Zero padding supplies the empty upper half of the last word when the
    // channel count is odd.
    shadow_next = '0;
    shadow_next[SAMPLE_W*MIC_N-1:0] = frame_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      word_idx   <= '0;
      word_ptr   <= '0;
      cur_bank   <= 1'b0;
      bank_full  <= '0;
      drop_count <= '0;
    end else begin
      bank_full <= bank_full_next;

      if (frame_take && !drop) begin
        shadow <= shadow_next;
      end

      if (drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end

      if (writing) begin
        word_idx <= last_word ? '0 : word_idx + 1'b1;
        if (bank_wrap) begin
          word_ptr <= '0;
          cur_bank <= ~cur_bank;
        end else begin
          word_ptr <= word_ptr + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
